// File: rtl/a_pattern_gen_if.sv
// Request/waveform bundle between a pattern requester and a_pattern_gen.
// With A_PATTERN_GEN_ABORT_EN defined, the bundle also carries Abort and Aborted.
interface a_pattern_gen_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned REP_W = 4
);
   logic             Go;
   logic [CNT_W-1:0] Len_hi;
   logic [CNT_W-1:0] Len_lo;
   logic [REP_W-1:0] Reps;
   logic             A;
   logic             Busy;
   logic             Done;
   logic [2:0]       state;
`ifdef A_PATTERN_GEN_ABORT_EN
   logic             Abort;
   logic             Aborted;

   modport master (output Go, Len_hi, Len_lo, Reps, Abort,
                   input  A, Busy, Done, state, Aborted);
   modport slave  (input  Go, Len_hi, Len_lo, Reps, Abort,
                   output A, Busy, Done, state, Aborted);
`else
   modport master (output Go, Len_hi, Len_lo, Reps,
                   input  A, Busy, Done, state);
   modport slave  (input  Go, Len_hi, Len_lo, Reps,
                   output A, Busy, Done, state);
`endif
endinterface

// File: rtl/a_pattern_gen.sv
// Drives the A line through Reps frames of high-low-high-low with programmable phase lengths.
// Optional abort support: define A_PATTERN_GEN_ABORT_EN.
module a_pattern_gen #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned REP_W = 4
) (
   input logic            Clock,
   input logic            Reset,
   a_pattern_gen_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HI1  = 3'd1,
      LO1  = 3'd2,
      HI2  = 3'd3,
      LO2  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             a_q, a_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [REP_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] lo_q, lo_d;
   logic             aborted_q, aborted_d;

   logic [CNT_W-1:0] hi_eff, lo_eff;
   logic [REP_W-1:0] reps_eff;

   // Zero-valued requests behave as length/count of one.
   assign hi_eff   = (bus.Len_hi == '0) ? CNT_W'(1) : bus.Len_hi;
   assign lo_eff   = (bus.Len_lo == '0) ? CNT_W'(1) : bus.Len_lo;
   assign reps_eff = (bus.Reps   == '0) ? REP_W'(1) : bus.Reps;

   // State and datapath registers; Reset overrides everything.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         a_q       <= 1'b0;
         done_q    <= 1'b0;
         phase_q   <= '0;
         frame_q   <= '0;
         hi_q      <= CNT_W'(1);
         lo_q      <= CNT_W'(1);
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         done_q    <= done_d;
         phase_q   <= phase_d;
         frame_q   <= frame_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         aborted_q <= aborted_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      done_d    = 1'b0;
      phase_d   = phase_q;
      frame_d   = frame_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      aborted_d = aborted_q;

      case (state_q)
         IDLE: begin
            a_d = 1'b0;
            if (bus.Go) begin
               hi_d      = hi_eff;
               lo_d      = lo_eff;
               phase_d   = hi_eff - CNT_W'(1);
               frame_d   = reps_eff - REP_W'(1);
               aborted_d = 1'b0;
               state_d   = HI1;
               a_d       = 1'b1;
            end
         end
         HI1: begin
            if (phase_q == '0) begin
               state_d = LO1;
               phase_d = lo_q - CNT_W'(1);
               a_d     = 1'b0;
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end
         LO1: begin
            if (phase_q == '0) begin
               state_d = HI2;
               phase_d = hi_q - CNT_W'(1);
               a_d     = 1'b1;
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end
         HI2: begin
            if (phase_q == '0) begin
               state_d = LO2;
               phase_d = lo_q - CNT_W'(1);
               a_d     = 1'b0;
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end
         LO2: begin
            if (phase_q == '0) begin
               if (frame_q != '0) begin
                  // Next frame starts back-to-back with no idle gap.
                  state_d = HI1;
                  frame_d = frame_q - REP_W'(1);
                  phase_d = hi_q - CNT_W'(1);
                  a_d     = 1'b1;
               end else begin
                  state_d = IDLE;
                  a_d     = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            a_d     = 1'b0;
         end
      endcase

`ifdef A_PATTERN_GEN_ABORT_EN
      if ((state_q != IDLE) && bus.Abort) begin
         state_d   = IDLE;
         a_d       = 1'b0;
         done_d    = 1'b0;
         aborted_d = 1'b1;
      end
`endif
   end

   assign bus.A     = a_q;
   assign bus.Done  = done_q;
   assign bus.Busy  = (state_q != IDLE);
   assign bus.state = 3'(state_q);
`ifdef A_PATTERN_GEN_ABORT_EN
   assign bus.Aborted = aborted_q;
`else
   logic unused_aborted;
   assign unused_aborted = aborted_q;
`endif

endmodule
